planificador_rr: RTL and testbench
==================================

// Module: planificador_rr
// PURPOSE
// - Weighted round-robin pop scheduler for the 4 input VC FIFOs feeding the 1:4 routing stage.
// - Pops at most one FIFO per cycle and routes the word one cycle later to the output FIFO named by its dest field.
// - Stalls on any output almost-full condition.
// - Replaces fixed-priority service so that VC0 traffic cannot starve VC1..VC3.
// PARAMETERS
// - WEIGHT  4   pops granted per turn (quantum), legal 1..15
// - CW      4   credit counter width, must hold WEIGHT
// - STAT_W  16  width of each pop counter (STATS_EN only)
// PORTS
// - clk        in   1        clock, all state updates on posedge
// - reset      in   1        synchronous, active-high; samples high -> all state cleared at that edge
// - empty      in   4        input FIFO i empty
// - aempty     in   4        input FIFO i holds <=1 word
// - afull      in   4        output FIFO j almost full
// - dest       in   2        dest field of word on selected FIFO output; valid the cycle after a pop
// - pop        out  4        one-hot pop to input FIFO i (registered)
// - push       out  4        one-hot push to output FIFO j
// - sel        out  2        input mux select; equals index of the FIFO popped in the previous cycle
// - busy       out  1        high when FSM is not IDLE
// - pop_cnt    out  4*STAT_W packed per-queue pop counts, queue i at [i*STAT_W +: STAT_W] (STATS_EN only)
// BEHAVIOUR
// - Reset values: pop=0, push=0, sel=0, busy=0, rr_ptr=0, credit=0, state=IDLE, pop_cnt=0.
// - Reset mid-operation: an in-flight word is dropped (push stays 0 the cycle after reset).
// - any_afull = |afull. valid_d1 = |pop of previous cycle; g = grant index.
// - push = (valid_d1 && !reset) ? onehot(dest) : 0, so the push is combinational on dest.
// - sel, valid_d1 registered: latency pop->push = 1 cycle.
// - States and transitions:
//   - IDLE: if !any_afull and any !empty[i], grant first non-empty queue scanning rr_ptr, rr_ptr+1, ... mod 4.
//     Load credit=WEIGHT, pop[g]=1 next cycle, go to SERVE. Else stay, pop=0.
//   - SERVE: each pop cycle decrements credit.
//     - any_afull -> STALL, pop=0 next cycle.
//     - credit hits 0 or queue g empty -> rr_ptr=g+1 mod 4, regrant immediately as in IDLE; no regrant possible -> IDLE.
//     - Back-to-back pop of the same g only if !aempty[g]; otherwise insert one idle cycle, then re-check empty[g].
//   - STALL: pop=0; grant and credit held. Enter SERVE when any_afull drops. If empty[g] at exit, rotate as above.
// - afull raised while a word is in flight: that word is still pushed (afull leaves >=1 slot of margin).
// - Never more than one pop bit or one push bit asserted.
// - Never pop a queue whose empty=1 in the deciding cycle.
// - Rotation: after granting g, the next scan starts at g+1 mod 4; a queue that goes empty forfeits its remaining credit.
// - A new arrival in a higher-index queue never preempts the current grant.
// CONFIGURATION
// - STATS_EN defined: pop_cnt[i] increments on every pop[i] and wraps at 2^STAT_W-1 -> 0; cleared by reset.
// - STATS_EN undefined: pop_cnt port and counters absent; all other behaviour identical.
// TESTING
// - Reset: assert reset 2 cycles with all FIFOs non-empty -> pop=0, push=0, sel=0, busy=0 throughout; first pop[0] 2 cycles after release.
// - WRR, WEIGHT=4, all queues deep -> pop sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
//   push[dest] one cycle after each pop, sel matching.
// - Only queue 2 holds 1 word (aempty[2]=1, dest=3) -> one pop[2], push[3] next cycle, then IDLE with busy=0.
// - afull[1]=1 mid-turn on queue 0 after 2 pops -> pending word still pushed, pop=0 while afull.
//   On release, exactly 2 more pops of queue 0, then queue 1.
// - Queue 1 empties after 2 of 4 credits -> next grant is queue 2, no pop of queue 1 with empty=1.
// - STATS_EN: 70000 pops on queue 3 with STAT_W=16 -> pop_cnt[3] = 70000-65536 = 4464; other counts 0.

Source files
------------

// File: rtl/planificador_rr.sv
`default_nettype none
// ============================================================================
// Module      : planificador_rr
// Description : Weighted round-robin pop scheduler for four input VC FIFOs.
//               Pops at most one FIFO per cycle and pushes the popped word one
//               cycle later into the output FIFO selected by its dest field.
//               All popping stalls while any output FIFO is almost full.
//               Optional macro STATS_EN adds per-queue wrapping pop counters
//               on port pop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module planificador_rr #(
    parameter int WEIGHT = 4,   // pops granted per turn, 1..15
    parameter int CW     = 4,   // credit counter width, must hold WEIGHT
    parameter int STAT_W = 16   // width of each pop counter
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          empty,
    input  logic [3:0]          aempty,
    input  logic [3:0]          afull,
    input  logic [1:0]          dest,
    output logic [3:0]          pop,
    output logic [3:0]          push,
    output logic [1:0]          sel,
    output logic                busy
`ifdef STATS_EN
    ,
    output logic [4*STAT_W-1:0] pop_cnt
`endif
);

    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_SERVE  = 2'd1;
    localparam logic [1:0]    S_STALL  = 2'd2;
    localparam logic [CW-1:0] C_WEIGHT = CW'(WEIGHT);

    logic [1:0]    state_q,  state_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;   // scan start; set to g+1 whenever g is granted
    logic [1:0]    g_q,      g_d;        // currently granted queue
    logic [CW-1:0] credit_q, credit_d;   // pops left in the current turn
    logic [3:0]    pop_q,    pop_d;
    logic          valid_d1_q;           // a word was popped in the previous cycle
    logic [1:0]    sel_q;

    logic          w_any_afull;
    logic [3:0]    w_elig;
    logic          w_scan_hit;
    logic [1:0]    w_scan_idx;
    logic [CW-1:0] w_credit_after;
    logic          w_rotate;

    assign w_any_afull = |afull;

    // A queue being popped right now with at most one word may be empty after
    // this pop, so it cannot be popped again back-to-back.
    assign w_elig = ~empty & ~(pop_q & aempty);

    // The pop currently on the bus consumes one credit.
    assign w_credit_after = (|pop_q) ? (credit_q - CW'(1)) : credit_q;

    // First eligible queue scanning rr_ptr, rr_ptr+1, ... (mod 4).
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (w_elig[rr_ptr_q + 2'(k)]) begin
                w_scan_hit = 1'b1;
                w_scan_idx = rr_ptr_q + 2'(k);
            end
        end
    end

    // Grant/credit state machine; decides the registered pop for next cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        g_d      = g_q;
        credit_d = credit_q;
        pop_d    = 4'b0000;
        w_rotate = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_rotate = !w_any_afull;
            end
            S_SERVE: begin
                credit_d = w_credit_after;
                if (w_any_afull) begin
                    state_d = S_STALL;
                end else if ((w_credit_after == '0) || empty[g_q]) begin
                    w_rotate = 1'b1;
                end else if (w_elig[g_q]) begin
                    pop_d[g_q] = 1'b1;
                end
                // otherwise: one idle cycle, empty[g] is re-checked next cycle
            end
            S_STALL: begin
                if (!w_any_afull) begin
                    if ((credit_q == '0) || empty[g_q]) begin
                        w_rotate = 1'b1;
                    end else begin
                        pop_d[g_q] = 1'b1;
                        state_d    = S_SERVE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // New turn: a queue that ran dry forfeits whatever credit it had left.
        if (w_rotate) begin
            if (w_scan_hit) begin
                g_d               = w_scan_idx;
                rr_ptr_d          = w_scan_idx + 2'd1;
                credit_d          = C_WEIGHT;
                pop_d[w_scan_idx] = 1'b1;
                state_d           = S_SERVE;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Scheduler state, registered pop and the one-cycle pop->push pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 2'd0;
            g_q        <= 2'd0;
            credit_q   <= '0;
            pop_q      <= 4'b0000;
            valid_d1_q <= 1'b0;
            sel_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            g_q        <= g_d;
            credit_q   <= credit_d;
            pop_q      <= pop_d;
            valid_d1_q <= |pop_q;
            if (|pop_q) begin
                sel_q <= {pop_q[3] | pop_q[2], pop_q[3] | pop_q[1]};
            end
        end
    end

    assign pop  = pop_q;
    assign sel  = sel_q;
    assign busy = (state_q != S_IDLE);
    // Push follows dest combinationally; an in-flight word is dropped by reset.
    assign push = (valid_d1_q && !reset) ? (4'b0001 << dest) : 4'b0000;

`ifdef STATS_EN
    for (genvar i = 0; i < 4; i++) begin : g_stats
        logic [STAT_W-1:0] cnt_q;
        // Free-running per-queue pop counter, wraps naturally.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (pop_q[i]) begin
                cnt_q <= cnt_q + STAT_W'(1);
            end
        end
        assign pop_cnt[i*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_planificador_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_planificador_rr
// Description : Self-checking bench for planificador_rr. Input FIFOs are
//               modelled as word counts; a policy-level model predicts the pop
//               and push stream, plus literal expectations for key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_planificador_rr;

    localparam int WEIGHT = 4;
    localparam int STAT_W = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] empty, aempty, afull;
    logic [1:0] dest;
    logic [3:0] pop, push;
    logic [1:0] sel;
    logic       busy;
`ifdef STATS_EN
    logic [4*STAT_W-1:0] pop_cnt;
`endif

    planificador_rr #(.WEIGHT(WEIGHT), .CW(4), .STAT_W(STAT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .empty  (empty),
        .aempty (aempty),
        .afull  (afull),
        .dest   (dest),
        .pop    (pop),
        .push   (push),
        .sel    (sel),
        .busy   (busy)
`ifdef STATS_EN
        ,
        .pop_cnt(pop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- input FIFO environment ----------------
    bit         deep [4];    // effectively bottomless queue
    int         fcnt [4];    // words held by a finite queue
    logic [1:0] fdest[4];    // dest of every word in a finite queue
    int         dcnt [4];    // words taken from a deep queue so far

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            empty[i]  = !deep[i] && (fcnt[i] == 0);
            aempty[i] = !deep[i] && (fcnt[i] <= 1);
        end
    endtask

    task automatic setq(input int i, input bit dp, input int c, input logic [1:0] d);
        deep[i]  = dp;
        fcnt[i]  = c;
        fdest[i] = d;
    endtask

    task automatic fifo_update(input logic [3:0] pv);
        for (int i = 0; i < 4; i++) begin
            if (pv[i] === 1'b1) begin
                if (deep[i]) begin
                    dest = 2'((i + dcnt[i]) % 4);
                    dcnt[i]++;
                end else if (fcnt[i] > 0) begin
                    fcnt[i]--;
                    dest = fdest[i];
                end
            end
        end
        refresh();
    endtask

    // ---------------- policy model ----------------
    // m_cur: queue holding the turn (-1 none), m_left: pops left in the turn,
    // m_start: where the next search begins, m_pop: expected pop this cycle,
    // m_prev: queue popped last cycle (its word is pushed this cycle).
    int m_cur = -1, m_left = 0, m_start = 0, m_pop = -1, m_prev = -1;

    function automatic bit can_pop(input int i, input int popped);
        return !empty[i] && !(popped == i && aempty[i]);
    endfunction

    task automatic model_edge();
        int popped, nxt;
        if (reset) begin
            m_cur = -1; m_left = 0; m_start = 0; m_pop = -1; m_prev = -1;
            return;
        end
        popped = m_pop;
        nxt    = -1;
        if (popped >= 0) m_left--;
        if (m_cur >= 0 && afull != 4'b0) begin
            // stalled: keep turn and remaining quantum
        end else if (m_cur < 0 || m_left == 0 || empty[m_cur]) begin
            if (afull == 4'b0) begin
                m_cur = -1;
                for (int k = 0; k < 4; k++) begin
                    int q;
                    q = (m_start + k) % 4;
                    if (can_pop(q, popped)) begin
                        m_cur = q; m_left = WEIGHT; m_start = (q + 1) % 4; nxt = q;
                        break;
                    end
                end
            end
        end else if (can_pop(m_cur, popped)) begin
            nxt = m_cur;
        end
        m_prev = popped;
        m_pop  = nxt;
    endtask

    task automatic tick();
        logic [3:0] pv;
        @(negedge clk);
        pv = pop;
        @(posedge clk);
        model_edge();
        #1;
        fifo_update(pv);
        #1;
    endtask

    function automatic int idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) return i;
        return -1;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pop",  {28'd0, pop},  (m_pop >= 0) ? (32'd1 << m_pop) : 32'd0);
            chk("busy", {31'd0, busy}, (m_cur >= 0) ? 32'd1 : 32'd0);
            chk("push", {28'd0, push}, (m_prev >= 0 && !reset) ? (32'd1 << dest) : 32'd0);
            if (m_prev >= 0) chk("sel", {30'd0, sel}, m_prev);
            chk("pop_on_empty", {28'd0, pop & empty}, 32'd0);
        end
    end

    // ---------------- directed scenarios ----------------
    int seq[20];
    int c_wrr[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    int c_afl[4]  = '{0,0,1,1};
    int c_emp[5]  = '{1,1,-1,2,2};

    task automatic start_test();
        reset = 1'b1;
        afull = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        afull = 4'b0000;
        dest  = 2'd0;
        for (int i = 0; i < 4; i++) begin setq(i, 1'b1, 0, 2'd0); dcnt[i] = 0; end
        refresh();

        // Reset held two cycles with all queues non-empty, then WRR service.
        tick();
        chk_en = 1'b1;
        chk("rst_pop", {28'd0, pop}, 0);  chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sel", {30'd0, sel}, 0);  chk("rst_push", {28'd0, push}, 0);
        tick();
        chk("rst_pop2", {28'd0, pop}, 0); chk("rst_busy2", {31'd0, busy}, 0);
        chk("rst_sel2", {30'd0, sel}, 0); chk("rst_push2", {28'd0, push}, 0);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            seq[k] = idx(pop);
        end
        for (int k = 0; k < 17; k++) chk($sformatf("wrr_seq%0d", k), seq[k], c_wrr[k]);

        // Single word in queue 2 going to output 3.
        start_test();
        for (int i = 0; i < 4; i++) setq(i, 1'b0, 0, 2'd0);
        setq(2, 1'b0, 1, 2'd3);
        refresh();
        tick();
        reset = 1'b0;
        tick();
        chk("single_pop", {28'd0, pop}, 32'h4);
        chk("single_busy", {31'd0, busy}, 1);
        tick();
        chk("single_push", {28'd0, push}, 32'h8);
        chk("single_nopop", {28'd0, pop}, 0);
        tick();
        chk("single_idle", {31'd0, busy}, 0);
        tick();
        chk("single_nopush", {28'd0, push}, 0);

        // afull raised during the second pop of queue 0's turn.
        start_test();
        for (int i = 0; i < 4; i++) setq(i, 1'b0, 0, 2'd0);
        setq(0, 1'b1, 0, 2'd0);
        setq(1, 1'b1, 0, 2'd0);
        refresh();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("afl_pre_pop", idx(pop), 0);
        afull = 4'b0010;
        tick();
        chk("afl_stall_pop", {28'd0, pop}, 0);
        chk("afl_inflight_push", {31'd0, (push != 4'b0)}, 1);
        tick();
        chk("afl_stall_pop2", {28'd0, pop}, 0);
        tick();
        chk("afl_stall_pop3", {28'd0, pop}, 0);
        afull = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            seq[k] = idx(pop);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("afl_seq%0d", k), seq[k], c_afl[k]);

        // Queue 1 runs dry after 2 of its 4 credits; queue 2 takes over.
        start_test();
        for (int i = 0; i < 4; i++) setq(i, 1'b0, 0, 2'd0);
        setq(1, 1'b0, 2, 2'd1);
        setq(2, 1'b1, 0, 2'd0);
        refresh();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seq[k] = idx(pop);
        end
        for (int k = 0; k < 5; k++) chk($sformatf("emp_seq%0d", k), seq[k], c_emp[k]);

        // Reset while a word is in flight: nothing is pushed.
        reset = 1'b1;
        #1;
        chk("midrst_push", {28'd0, push}, 0);
        tick();
        chk("midrst_push2", {28'd0, push}, 0);
        chk("midrst_pop", {28'd0, pop}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        tick();

`ifdef STATS_EN
        // 70000 pops on queue 3 wrap its 16-bit counter to 4464.
        begin
            int n3;
            bit done;
            start_test();
            for (int i = 0; i < 4; i++) setq(i, 1'b0, 0, 2'd0);
            setq(3, 1'b1, 0, 2'd0);
            refresh();
            tick();
            reset = 1'b0;
            n3   = 0;
            done = 1'b0;
            for (int t = 0; t < 80000 && !done; t++) begin
                tick();
                if (pop[3] === 1'b1) n3++;
                if (n3 == 70000) done = 1'b1;
            end
            chk("stats_reached", {31'd0, done}, 1);
            afull = 4'b0001;
            tick();
            tick();
            chk("stats_q3", {16'd0, pop_cnt[3*STAT_W +: STAT_W]}, 4464);
            chk("stats_q0", {16'd0, pop_cnt[0*STAT_W +: STAT_W]}, 0);
            chk("stats_q1", {16'd0, pop_cnt[1*STAT_W +: STAT_W]}, 0);
            chk("stats_q2", {16'd0, pop_cnt[2*STAT_W +: STAT_W]}, 0);
            afull = 4'b0000;
        end
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
